// File: rtl/ee457_mcpu_seq.sv
// Multi-cycle MIPS-subset control sequencer: FETCH/DECODE plus per-class
// execute states, a retired-instruction counter and a sticky illegal flag.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   op, func         opcode / function field from the instruction register
//   zero, mem_rdy    ALU zero flag, memory access completes this cycle
//   pcwrite..mtor    datapath controls (Moore on state, except FETCH on
//                    mem_rdy and BRANCH on zero)
//   state            current state encoding
//   instr_cnt        retired instruction count (wraps)
//   illegal          sticky: an unknown opcode reached DECODE
module ee457_mcpu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_rdy,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        iord,
    output logic        mr,
    output logic        mw,
    output logic        regw,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic [1:0]  pcsrc,
    output logic [1:0]  rdst,
    output logic [1:0]  mtor,
    output logic [3:0]  state,
    output logic [15:0] instr_cnt,
    output logic        illegal
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_illegal;

    // One-hot opcode class decode; these are mutually exclusive.
    logic w_is_mem;
    logic w_is_lw;
    logic w_is_jr;
    logic w_is_rt;
    logic w_is_br;
    logic w_is_j;
    logic w_is_jal;
    logic w_is_addi;
    logic w_is_beq;
    logic w_retire;
    logic w_set_ill;

    assign w_is_lw   = (op == OP_LW);
    assign w_is_mem  = w_is_lw || (op == OP_SW);
    assign w_is_jr   = (op == OP_RTYPE) && (func == FN_JR);
    assign w_is_rt   = (op == OP_RTYPE) && (func != FN_JR);
    assign w_is_beq  = (op == OP_BEQ);
    assign w_is_br   = w_is_beq || (op == OP_BNE);
    assign w_is_j    = (op == OP_J);
    assign w_is_jal  = (op == OP_JAL);
    assign w_is_addi = (op == OP_ADDI);

    always_comb begin
        w_next  = r_state;
        pcwrite = 1'b0;
        irwrite = 1'b0;
        iord    = 1'b0;
        mr      = 1'b0;
        mw      = 1'b0;
        regw    = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        aluop   = 2'b00;
        pcsrc   = 2'b00;
        rdst    = 2'b00;
        mtor    = 2'b00;

        unique case (r_state)
            S_FETCH: begin
                mr      = 1'b1;
                alusrcb = 2'b01;
                if (mem_rdy) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                unique case (1'b1)
                    w_is_mem:  w_next = S_MEMADR;
                    w_is_jr:   w_next = S_JR;
                    w_is_rt:   w_next = S_EXEC;
                    w_is_br:   w_next = S_BRANCH;
                    w_is_j:    w_next = S_JUMP;
                    w_is_jal:  w_next = S_JAL;
                    w_is_addi: w_next = S_ADDIEX;
                    default:   w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = w_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                mr   = 1'b1;
                if (mem_rdy) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regw   = 1'b1;
                mtor   = 2'b01;
                w_next = S_FETCH;
            end
            S_MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
                if (mem_rdy) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                regw   = 1'b1;
                rdst   = 2'b01;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcwrite = w_is_beq ? zero : ~zero;
                w_next  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                w_next  = S_FETCH;
            end
            S_JAL: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                regw    = 1'b1;
                rdst    = 2'b10;
                mtor    = 2'b10;
                w_next  = S_FETCH;
            end
            S_JR: begin
                pcsrc   = 2'b11;
                pcwrite = 1'b1;
                w_next  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regw   = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset wins over whatever state the register happens to hold,
        // so no write or memory strobe escapes while rst is high.
        if (rst) begin
            pcwrite = 1'b0;
            irwrite = 1'b0;
            iord    = 1'b0;
            mr      = 1'b0;
            mw      = 1'b0;
            regw    = 1'b0;
            alusrca = 1'b0;
            alusrcb = 2'b00;
            aluop   = 2'b00;
            pcsrc   = 2'b00;
            rdst    = 2'b00;
            mtor    = 2'b00;
        end
    end

    // DECODE only returns to FETCH on an illegal opcode, so it never
    // counts as a retirement.
    assign w_retire  = (r_state != S_FETCH) && (r_state != S_DECODE) &&
                       (w_next == S_FETCH);
    assign w_set_ill = (r_state == S_DECODE) && (w_next == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + 16'h0001;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_cnt;
    assign illegal   = r_illegal;

endmodule
